// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the responder state type.
// lane_enable maps a transfer size and byte offset onto the four little-endian byte lanes.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } slave_state_e;

    function automatic logic [3:0] lane_enable(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] lanes;
        case (size)
            HSIZE_BYTE: lanes = 4'b0001 << addr_lo;
            HSIZE_HALF: lanes = addr_lo[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: lanes = 4'b1111;
            default:    lanes = 4'b0000;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/ahb_byte_ram.sv
// DEPTH x 32 memory with per-byte write enables, asynchronous read and a
// synchronous active-low clear of every word.
module ahb_byte_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite responder over ahb_byte_ram: captures the address phase, inserts
// WAIT_STATES wait cycles, and answers illegal accesses with a two-cycle ERROR.
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic        CLK_SLAVE,
    input  logic        RESET_SLAVE,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    output logic        HREADY,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int         AW        = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    slave_state_e  state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [1:0]    lo_q, lo_d;
    logic [2:0]    size_q, size_d;
    logic          write_q, write_d;
    logic          hready_q, hready_d;
    logic          hresp_q, hresp_d;

    logic          accept;
    logic          illegal;
    logic [3:0]    ram_we;
    logic [31:0]   ram_rdata;
    logic          unused_hburst;

    // Every beat carries its own address, so the burst type carries no information here.
    assign unused_hburst = ^HBURST;

    assign accept  = hready_q && HSEL && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
    assign illegal = (HADDR[31:2] >= 30'(DEPTH))
                  || (HSIZE > HSIZE_WORD)
                  || (HSIZE == HSIZE_HALF && HADDR[0])
                  || (HSIZE == HSIZE_WORD && HADDR[1:0] != 2'b00);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        lo_d    = lo_q;
        size_d  = size_q;
        write_d = write_q;
        case (state_q)
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                // S_IDLE, S_DATA and S_ERR2 all drive HREADY high and may accept a new transfer.
                state_d = S_IDLE;
                if (accept) begin
                    idx_d   = HADDR[AW+1:2];
                    lo_d    = HADDR[1:0];
                    size_d  = HSIZE;
                    write_d = HWRITE;
                    cnt_d   = WAIT_LOAD;
                    if (illegal) begin
                        state_d = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
        endcase
        hready_d = !(state_d == S_WAIT || state_d == S_ERR1);
        hresp_d  = (state_d == S_ERR1 || state_d == S_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    end

    always_ff @(posedge CLK_SLAVE) begin
        if (!RESET_SLAVE) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            lo_q     <= '0;
            size_q   <= '0;
            write_q  <= 1'b0;
            hready_q <= 1'b1;
            hresp_q  <= HRESP_OKAY;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            lo_q     <= lo_d;
            size_q   <= size_d;
            write_q  <= write_d;
            hready_q <= hready_d;
            hresp_q  <= hresp_d;
        end
    end

    assign ram_we = (state_q == S_DATA && write_q) ? lane_enable(size_q, lo_q) : 4'b0000;

    ahb_byte_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (CLK_SLAVE),
        .rst_n (RESET_SLAVE),
        .we    (ram_we),
        .waddr (idx_q),
        .wdata (HWDATA),
        .raddr (idx_q),
        .rdata (ram_rdata)
    );

    assign HREADY = hready_q;
    assign HRESP  = hresp_q;
    assign HRDATA = (state_q == S_DATA) ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Randomized and directed bench for ahb_slave_mem with zero and three wait states,
// checked against a transaction-level memory model.
module tb_ahb_slave_mem;

    localparam int DEPTH = 16;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [31:0] wdata;
    } xfer_t;

    logic        clk = 1'b0;
    logic        rst_n  [2];
    logic        hsel   [2];
    logic [31:0] haddr  [2];
    logic        hwrite [2];
    logic [2:0]  hsize  [2];
    logic [2:0]  hburst [2];
    logic [1:0]  htrans [2];
    logic [31:0] hwdata [2];
    logic        hready [2];
    logic        hresp  [2];
    logic [31:0] hrdata [2];

    logic [31:0] modelMem [2][DEPTH];
    xfer_t       q [$];
    int          checkCount = 0;
    int          passCount  = 0;

    always #5 clk = ~clk;

    ahb_slave_mem #(.DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
        .CLK_SLAVE(clk), .RESET_SLAVE(rst_n[0]), .HSEL(hsel[0]), .HADDR(haddr[0]),
        .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(hburst[0]), .HTRANS(htrans[0]),
        .HWDATA(hwdata[0]), .HREADY(hready[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0])
    );

    ahb_slave_mem #(.DEPTH(DEPTH), .WAIT_STATES(3)) dut3 (
        .CLK_SLAVE(clk), .RESET_SLAVE(rst_n[1]), .HSEL(hsel[1]), .HADDR(haddr[1]),
        .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(hburst[1]), .HTRANS(htrans[1]),
        .HWDATA(hwdata[1]), .HREADY(hready[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1])
    );

    function automatic int waitOf(input int w);
        return (w == 0) ? 0 : 3;
    endfunction

    function automatic xfer_t idleX();
        xfer_t x;
        x.sel = 1'b0; x.trans = 2'b00; x.addr = '0; x.write = 1'b0; x.size = '0; x.wdata = '0;
        return x;
    endfunction

    function automatic bit isLegal(input xfer_t x);
        if ((x.addr >> 2) >= DEPTH) return 1'b0;
        if (x.size > 3'd2) return 1'b0;
        if (x.size == 3'd1 && x.addr[0]) return 1'b0;
        if (x.size == 3'd2 && x.addr[1:0] != 2'b00) return 1'b0;
        return 1'b1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic modelWrite(input int w, input xfer_t x);
        logic [31:0] word;
        int          idx;
        bit          hit;
        idx  = int'(x.addr >> 2);
        word = modelMem[w][idx];
        for (int b = 0; b < 4; b++) begin
            case (x.size)
                3'd0:    hit = (b == int'(x.addr[1:0]));
                3'd1:    hit = ((b / 2) == int'(x.addr[1]));
                default: hit = 1'b1;
            endcase
            if (hit) word[8*b +: 8] = x.wdata[8*b +: 8];
        end
        modelMem[w][idx] = word;
    endtask

    task automatic modelClear(input int w);
        for (int i = 0; i < DEPTH; i++) modelMem[w][i] = '0;
    endtask

    task automatic driveAddr(input int w, input xfer_t x);
        hsel[w]   = x.sel;
        htrans[w] = x.trans;
        haddr[w]  = x.addr;
        hwrite[w] = x.write;
        hsize[w]  = x.size;
        hburst[w] = 3'($urandom_range(0, 7));
    endtask

    task automatic pushX(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                         input logic write, input logic [2:0] size, input logic [31:0] wdata);
        xfer_t x;
        x.sel = sel; x.trans = trans; x.addr = addr; x.write = write; x.size = size; x.wdata = wdata;
        q.push_back(x);
    endtask

    task automatic pushRandom();
        xfer_t x;
        int    r;
        x.sel   = ($urandom_range(0, 9) != 0);
        r       = $urandom_range(0, 9);
        x.trans = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r < 6) ? 2'b10 : 2'b11;
        x.size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        x.addr  = (32'($urandom_range(0, DEPTH + 1)) << 2) | 32'($urandom_range(0, 3));
        if (x.size == 3'd1 && $urandom_range(0, 3) != 0) x.addr[0] = 1'b0;
        if (x.size == 3'd2 && $urandom_range(0, 3) != 0) x.addr[1:0] = 2'b00;
        if ($urandom_range(0, 19) == 0) x.addr[31] = 1'b1;
        x.write = 1'($urandom_range(0, 1));
        x.wdata = $urandom;
        q.push_back(x);
    endtask

    // Pipelined master: drains the queue on DUT w, checking every data phase against the model.
    task automatic applyStimulus(input int w);
        xfer_t       ap, dp;
        bit          apReal, legal;
        int          dpKind, waits, expW, cyc;
        logic        hr, rs;
        logic [31:0] rd;
        ap = idleX(); dp = idleX(); apReal = 0; dpKind = 0; waits = 0; cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (cyc > 5000) begin
                checkOutput("cycle_budget", cyc, 5000);
                q.delete();
                return;
            end
            hr = hready[w]; rs = hresp[w]; rd = hrdata[w];
            if (dpKind == 2) begin
                legal = isLegal(dp);
                expW  = legal ? waitOf(w) : 1;
                if (!hr) begin
                    waits++;
                    checkOutput("wait_hresp", rs, legal ? 0 : 1);
                    checkOutput("wait_hrdata", rd, 0);
                    if (waits > 20) begin
                        checkOutput("wait_timeout", waits, expW);
                        q.delete();
                        return;
                    end
                end else begin
                    checkOutput($sformatf("waits_%08h", dp.addr), waits, expW);
                    checkOutput($sformatf("hresp_%08h", dp.addr), rs, legal ? 0 : 1);
                    if (!legal) checkOutput("err_hrdata", rd, 0);
                    else if (dp.write) modelWrite(w, dp);
                    else checkOutput($sformatf("rdata_%08h", dp.addr), rd, modelMem[w][int'(dp.addr >> 2)]);
                    dpKind = 0;
                end
            end else if (dpKind == 1) begin
                checkOutput("null_hready", hr, 1);
                checkOutput("null_hresp", rs, 0);
                checkOutput("null_hrdata", rd, 0);
                dpKind = 0;
            end
            if (hr) begin
                if (!apReal && q.size() == 0 && dpKind == 0) break;
                if (apReal && ap.sel && ap.trans[1]) begin
                    dp = ap; dpKind = 2; waits = 0;
                end else begin
                    dpKind = apReal ? 1 : 0;
                end
                if (q.size() > 0) begin
                    ap = q.pop_front(); apReal = 1;
                end else begin
                    ap = idleX(); apReal = 0;
                end
                @(posedge clk); #1;
                driveAddr(w, ap);
                hwdata[w] = (dpKind == 2 && dp.write) ? dp.wdata : $urandom;
            end
        end
    endtask

    task automatic doReset(input int w);
        @(posedge clk); #1;
        rst_n[w] = 1'b0;
        driveAddr(w, idleX());
        @(posedge clk); #1;
        rst_n[w] = 1'b1;
        modelClear(w);
        @(negedge clk);
        checkOutput("rst_hready", hready[w], 1);
        checkOutput("rst_hresp", hresp[w], 0);
        checkOutput("rst_hrdata", hrdata[w], 0);
    endtask

    initial begin
        for (int w = 0; w < 2; w++) begin
            rst_n[w] = 1'b0;
            driveAddr(w, idleX());
            hwdata[w] = '0;
            modelClear(w);
        end
        repeat (2) @(posedge clk);
        doReset(0);
        doReset(1);

        // Zero wait states: word write then read back.
        pushX(1, 2'b10, 32'h08, 1, 3'd2, 32'hDEADBEEF);
        pushX(1, 2'b10, 32'h08, 0, 3'd2, 32'h0);
        applyStimulus(0);

        // Byte and half-word lanes merged into one word.
        pushX(1, 2'b10, 32'h04, 1, 3'd2, 32'h00000000);
        pushX(1, 2'b10, 32'h05, 1, 3'd0, 32'h0000AA00);
        pushX(1, 2'b10, 32'h06, 1, 3'd1, 32'h12340000);
        pushX(1, 2'b10, 32'h04, 0, 3'd2, 32'h0);
        applyStimulus(0);

        // Illegal accesses, a NONSEQ accepted during the second error cycle, then word 0 untouched.
        pushX(1, 2'b10, 32'h40, 1, 3'd2, 32'h11111111);
        pushX(1, 2'b10, 32'h01, 0, 3'd1, 32'h0);
        pushX(1, 2'b10, 32'h00, 0, 3'd3, 32'h0);
        pushX(1, 2'b10, 32'h08, 0, 3'd2, 32'h0);
        pushX(1, 2'b10, 32'h00, 0, 3'd2, 32'h0);
        applyStimulus(0);

        // Pipelined write/read with IDLE, BUSY and deselected cycles between.
        pushX(1, 2'b10, 32'h10, 1, 3'd2, 32'h55AA1234);
        pushX(1, 2'b00, 32'h10, 1, 3'd2, 32'hFFFFFFFF);
        pushX(1, 2'b11, 32'h10, 0, 3'd2, 32'h0);
        pushX(1, 2'b01, 32'h10, 1, 3'd2, 32'hFFFFFFFF);
        pushX(0, 2'b10, 32'h10, 1, 3'd2, 32'hFFFFFFFF);
        pushX(1, 2'b10, 32'h10, 0, 3'd2, 32'h0);
        applyStimulus(0);

        for (int i = 0; i < 150; i++) pushRandom();
        applyStimulus(0);

        // Three wait states: single read then back-to-back SEQ reads.
        pushX(1, 2'b10, 32'h0C, 1, 3'd2, 32'hA5A5C3C3);
        pushX(1, 2'b10, 32'h0C, 0, 3'd2, 32'h0);
        pushX(1, 2'b10, 32'h00, 0, 3'd2, 32'h0);
        pushX(1, 2'b11, 32'h04, 0, 3'd2, 32'h0);
        pushX(1, 2'b11, 32'h08, 0, 3'd2, 32'h0);
        pushX(1, 2'b10, 32'h40, 0, 3'd2, 32'h0);
        applyStimulus(1);

        // Reset while a write to 0x14 is still waiting.
        @(posedge clk); #1;
        driveAddr(1, '{sel: 1'b1, trans: 2'b10, addr: 32'h14, write: 1'b1, size: 3'd2, wdata: 32'h0});
        hwdata[1] = $urandom;
        @(posedge clk); #1;
        driveAddr(1, idleX());
        hwdata[1] = 32'hCAFEF00D;
        @(negedge clk);
        checkOutput("mid_hready", hready[1], 0);
        @(posedge clk); #1;
        rst_n[1] = 1'b0;
        @(posedge clk); #1;
        rst_n[1] = 1'b1;
        modelClear(1);
        @(negedge clk);
        checkOutput("postrst_hready", hready[1], 1);
        checkOutput("postrst_hresp", hresp[1], 0);
        pushX(1, 2'b10, 32'h14, 0, 3'd2, 32'h0);
        applyStimulus(1);

        for (int i = 0; i < 100; i++) pushRandom();
        applyStimulus(1);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
